// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the dual-word SRAM bus master.
package sram_bus_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 16;

  // Control levels the bus rests at when no transaction is in flight.
  localparam logic CS_IDLE = 1'b1;
  localparam logic OE_READ = 1'b0;

  // WR_DONE is the bus-released cycle after WR_RELEASE. It gives writes the
  // same "CS high, then respond" tail that RD_CAPTURE gives reads.
  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_CAPTURE,
    WR_SETUP,
    WR_STROBE,
    WR_RELEASE,
    WR_DONE
  } state_t;

  // Width of a counter that runs 0 .. max(a,b)-1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sram_bus_master_if.sv
// Request/response handshake plus SRAM control and address pins.
// The bidirectional data buses stay as plain module ports.
interface sram_bus_master_if
  import sram_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr1;
  logic [ADDR_W-1:0] req_addr2;
  logic [DATA_W-1:0] req_wdata1;
  logic [DATA_W-1:0] req_wdata2;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata1;
  logic [DATA_W-1:0] rsp_rdata2;
  logic              rsp_err;
  logic              CS;
  logic              OE;
  logic              RW;
  logic [ADDR_W-1:0] MemAddress1;
  logic [ADDR_W-1:0] MemAddress2;

  modport master (
    input  req_valid, req_write, req_addr1, req_addr2, req_wdata1, req_wdata2,
    output req_ready, rsp_valid, rsp_rdata1, rsp_rdata2, rsp_err,
    output CS, OE, RW, MemAddress1, MemAddress2
  );

  modport slave (
    output req_valid, req_write, req_addr1, req_addr2, req_wdata1, req_wdata2,
    input  req_ready, rsp_valid, rsp_rdata1, rsp_rdata2, rsp_err,
    input  CS, OE, RW, MemAddress1, MemAddress2
  );

endinterface

// File: rtl/sram_io_buf.sv
// One SRAM data bus: tri-state driver toward the pad plus the sampled input path.
module sram_io_buf #(
  parameter int DATA_W = 16
) (
  input  logic              enable,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  inout  wire  [DATA_W-1:0] pad
);

  assign pad   = enable ? wdata : {DATA_W{1'bz}};
  assign rdata = pad;

endmodule

// File: rtl/sram_bus_master.sv
// Dual-word SRAM bus master: turns one valid/ready request into the SRAM
// read or write sequence and returns a one-cycle response.
// Optional macro SRAM_BUS_MASTER_READBACK_EN: every write is followed by a
// readback of both words, and rsp_err flags a mismatch.
module sram_bus_master
  import sram_bus_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_CYCLES  = 4,
  parameter int WRITE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  sram_bus_master_if.master bus,
  inout  wire  [DATA_W-1:0] MemData1,
  inout  wire  [DATA_W-1:0] MemData2
);

  localparam int CNT_W = cnt_width(READ_CYCLES, WRITE_CYCLES);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr1_reg, addr2_reg, addr1_next, addr2_next;
  logic [DATA_W-1:0] wdata1_reg, wdata2_reg;
  logic              cs_reg, oe_reg, rw_reg;
  logic              cs_next, oe_next, rw_next;
  logic [ADDR_W-1:0] mem_addr1_reg, mem_addr2_reg;
  logic              ready_reg, rsp_valid_reg, rsp_valid_next, capture;
  logic [DATA_W-1:0] rdata1_reg, rdata2_reg, mem_in1, mem_in2;
  logic              accept;

  assign accept = bus.req_valid && ready_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state, counter and request latch; pin levels decoded from the next
  // state so every pin is registered alongside the state it belongs to.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr1_next = addr1_reg;
    addr2_next = addr2_reg;
    cs_next    = CS_IDLE;
    oe_next    = OE_READ;
    rw_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          addr1_next = bus.req_addr1;
          addr2_next = bus.req_addr2;
          cnt_next   = '0;
          state_next = bus.req_write ? WR_SETUP : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_reg == RD_LAST) state_next = RD_CAPTURE;
        else                    cnt_next   = cnt_reg + 1'b1;
      end
      RD_CAPTURE: state_next = IDLE;
      WR_SETUP: begin
        cnt_next   = '0;
        state_next = WR_STROBE;
      end
      WR_STROBE: begin
        if (cnt_reg == WR_LAST) state_next = WR_RELEASE;
        else                    cnt_next   = cnt_reg + 1'b1;
      end
      WR_RELEASE: state_next = WR_DONE;
      WR_DONE: begin
`ifdef SRAM_BUS_MASTER_READBACK_EN
        cnt_next   = '0;
        state_next = RD_WAIT;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
    case (state_next)
      RD_WAIT: cs_next = 1'b0;
      WR_SETUP, WR_RELEASE: begin
        cs_next = 1'b0;
        oe_next = 1'b1;
      end
      WR_STROBE: begin
        cs_next = 1'b0;
        oe_next = 1'b1;
        rw_next = 1'b1;
      end
      default: ;
    endcase
    capture        = (state_reg == RD_WAIT) && (state_next == RD_CAPTURE);
    rsp_valid_next = ((state_reg == RD_CAPTURE) || (state_reg == WR_DONE)) &&
                     (state_next == IDLE);
  end

  // Registered pins, latched request and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      addr1_reg     <= '0;
      addr2_reg     <= '0;
      wdata1_reg    <= '0;
      wdata2_reg    <= '0;
      cs_reg        <= CS_IDLE;
      oe_reg        <= OE_READ;
      rw_reg        <= 1'b0;
      mem_addr1_reg <= '0;
      mem_addr2_reg <= '0;
      ready_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rdata1_reg    <= '0;
      rdata2_reg    <= '0;
    end else begin
      cnt_reg   <= cnt_next;
      addr1_reg <= addr1_next;
      addr2_reg <= addr2_next;
      if (accept) begin
        wdata1_reg <= bus.req_wdata1;
        wdata2_reg <= bus.req_wdata2;
      end
      cs_reg        <= cs_next;
      oe_reg        <= oe_next;
      rw_reg        <= rw_next;
      mem_addr1_reg <= (state_next == IDLE) ? '0 : addr1_next;
      mem_addr2_reg <= (state_next == IDLE) ? '0 : addr2_next;
      ready_reg     <= (state_next == IDLE);
      rsp_valid_reg <= rsp_valid_next;
      if (capture) begin
        rdata1_reg <= mem_in1;
        rdata2_reg <= mem_in2;
      end
    end
  end

`ifdef SRAM_BUS_MASTER_READBACK_EN
  logic readback_reg, mismatch_reg, err_reg;

  // Readback tracking: compare captured words against the written data.
  always_ff @(posedge clk) begin
    if (rst) begin
      readback_reg <= 1'b0;
      mismatch_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      if (state_reg == WR_DONE)     readback_reg <= 1'b1;
      else if (state_next == IDLE)  readback_reg <= 1'b0;
      if (capture)
        mismatch_reg <= readback_reg &&
                        ((mem_in1 != wdata1_reg) || (mem_in2 != wdata2_reg));
      err_reg <= rsp_valid_next && mismatch_reg;
    end
  end

  assign bus.rsp_err = err_reg;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // The data-bus enable is the OE register itself, so drive and OE always
  // change on the same edge.
  sram_io_buf #(.DATA_W(DATA_W)) io1 (
    .enable(oe_reg), .wdata(wdata1_reg), .rdata(mem_in1), .pad(MemData1)
  );
  sram_io_buf #(.DATA_W(DATA_W)) io2 (
    .enable(oe_reg), .wdata(wdata2_reg), .rdata(mem_in2), .pad(MemData2)
  );

  assign bus.req_ready   = ready_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_rdata1  = rdata1_reg;
  assign bus.rsp_rdata2  = rdata2_reg;
  assign bus.CS          = cs_reg;
  assign bus.OE          = oe_reg;
  assign bus.RW          = rw_reg;
  assign bus.MemAddress1 = mem_addr1_reg;
  assign bus.MemAddress2 = mem_addr2_reg;

endmodule

// File: tb/tb_sram_bus_master.sv
// Scoreboard bench for sram_bus_master with a behavioural dual-bus SRAM model.
module tb_sram_bus_master;

  localparam int RC = 4;
  localparam int WC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wire [15:0] MemData1, MemData2;

  sram_bus_master_if #(.ADDR_W(11), .DATA_W(16)) bus ();

  sram_bus_master #(
    .ADDR_W(11), .DATA_W(16), .READ_CYCLES(RC), .WRITE_CYCLES(WC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .MemData1(MemData1), .MemData2(MemData2)
  );

  // SRAM model: drives while selected for read; bit 0 flips on writes to addr 7.
  logic [15:0] mem [0:2047];
  logic        mem_init;
  assign MemData1 = (!bus.CS && !bus.OE) ? mem[bus.MemAddress1] : 16'hzzzz;
  assign MemData2 = (!bus.CS && !bus.OE) ? mem[bus.MemAddress2] : 16'hzzzz;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 16'hFFFF;
    end else if (!bus.CS && bus.RW) begin
      mem[bus.MemAddress1] <= MemData1 ^ ((bus.MemAddress1 == 11'd7) ? 16'h0001 : 16'h0000);
      mem[bus.MemAddress2] <= MemData2 ^ ((bus.MemAddress2 == 11'd7) ? 16'h0001 : 16'h0000);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    int          due;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        err;
    int          cs_low;
    int          rw_high;
    int          oe_high;
  } exp_t;

  exp_t sb[$];
  int   last_rsp_cyc = -100;
  logic [15:0] exp_rd1 = 16'h0000;
  logic [15:0] exp_rd2 = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: per-transaction pin accounting, pops the scoreboard on rsp_valid.
  initial begin
    int cs_cnt, rw_cnt, oe_cnt, viol;
    exp_t e;
    cs_cnt = 0; rw_cnt = 0; oe_cnt = 0; viol = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cs_cnt = 0; rw_cnt = 0; oe_cnt = 0; viol = 0;
      end else begin
        if (!bus.CS) cs_cnt++;
        if (bus.RW)  rw_cnt++;
        if (bus.OE)  oe_cnt++;
        if ((bus.OE && bus.CS) || (bus.RW && bus.CS)) viol++;
        if (bus.rsp_valid) begin
          last_rsp_cyc = cyc;
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, required 0 (nothing outstanding)", cyc);
          end else begin
            e = sb.pop_front();
            check({e.name, "_latency"}, cyc, e.due);
            check({e.name, "_rdata1"}, bus.rsp_rdata1, e.d1);
            check({e.name, "_rdata2"}, bus.rsp_rdata2, e.d2);
            check({e.name, "_err"}, bus.rsp_err, e.err);
            check({e.name, "_cs_low"}, cs_cnt, e.cs_low);
            check({e.name, "_rw_high"}, rw_cnt, e.rw_high);
            check({e.name, "_oe_high"}, oe_cnt, e.oe_high);
            check({e.name, "_bus_rules"}, viol, 0);
            check({e.name, "_ready_with_rsp"}, bus.req_ready, 1'b1);
            $display("rsp %s: cycle %0d rdata=%h/%h err=%0b cs_low=%0d rw=%0d",
                     e.name, cyc, bus.rsp_rdata1, bus.rsp_rdata2, bus.rsp_err, cs_cnt, rw_cnt);
          end
          cs_cnt = 0; rw_cnt = 0; oe_cnt = 0; viol = 0;
        end
      end
    end
  end

  // Issue one request from a negedge; pushes the expected response on acceptance.
  task automatic send(input string name, input logic w,
                      input logic [10:0] a1, input logic [10:0] a2,
                      input logic [15:0] d1, input logic [15:0] d2,
                      input logic [15:0] ed1, input logic [15:0] ed2,
                      input bit keep, input bit b2b);
    exp_t e;
    int   n;
    int   lat;
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_addr1  = a1;
    bus.req_addr2  = a2;
    bus.req_wdata1 = d1;
    bus.req_wdata2 = d2;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_accept: req_ready=0 after %0d cycles, required 1", name, n);
      bus.req_valid = 1'b0;
      return;
    end
    e.name = name;
    e.err  = 1'b0;
    if (!w) begin
      lat = RC + 1;
      e.cs_low = RC; e.rw_high = 0; e.oe_high = 0;
      e.d1 = ed1; e.d2 = ed2;
      exp_rd1 = ed1; exp_rd2 = ed2;
    end else begin
      e.rw_high = WC; e.oe_high = WC + 2;
`ifdef SRAM_BUS_MASTER_READBACK_EN
      lat = WC + RC + 4;
      e.cs_low = WC + 2 + RC;
      e.d1 = d1 ^ ((a1 == 11'd7) ? 16'h0001 : 16'h0000);
      e.d2 = d2 ^ ((a2 == 11'd7) ? 16'h0001 : 16'h0000);
      e.err = (e.d1 != d1) || (e.d2 != d2);
      exp_rd1 = e.d1; exp_rd2 = e.d2;
`else
      lat = WC + 3;
      e.cs_low = WC + 2;
      e.d1 = exp_rd1; e.d2 = exp_rd2;
`endif
    end
    e.due = cyc + 1 + lat;
    sb.push_back(e);
    $display("req %s: write=%0b addr=%0d/%0d wdata=%h/%h accepted at edge %0d",
             name, w, a1, a2, d1, d2, cyc + 1);
    @(negedge clk);
    if (b2b) check({name, "_b2b_accept_edge"}, cyc, last_rsp_cyc + 1);
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr1  = '0;
    bus.req_addr2  = '0;
    bus.req_wdata1 = '0;
    bus.req_wdata2 = '0;
    rst      = 1'b1;
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
    @(negedge clk);

    // Reset values.
    check("rst_CS", bus.CS, 1'b1);
    check("rst_OE", bus.OE, 1'b0);
    check("rst_RW", bus.RW, 1'b0);
    check("rst_addr1", bus.MemAddress1, 11'd0);
    check("rst_addr2", bus.MemAddress2, 11'd0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rdata1", bus.rsp_rdata1, 16'h0000);
    check("rst_rdata2", bus.rsp_rdata2, 16'h0000);
    check("rst_err", bus.rsp_err, 1'b0);
    check("rst_ready", bus.req_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.req_ready, 1'b1);

    // Single write then read of the same addresses.
    send("wr_5_2042", 1'b1, 11'd5, 11'd2042, 16'h1234, 16'hABCD, 16'h0, 16'h0, 1'b0, 1'b0);
    wait_idle("wr_5_2042");
    check("mem_5", mem[5], 16'h1234);
    check("mem_2042", mem[2042], 16'hABCD);
    send("rd_5_2042", 1'b0, 11'd5, 11'd2042, 16'h0, 16'h0, 16'h1234, 16'hABCD, 1'b0, 1'b0);
    wait_idle("rd_5_2042");

    // Back-to-back read, read, write with req_valid held high.
    send("b2b_rd_a", 1'b0, 11'd2042, 11'd5, 16'h0, 16'h0, 16'hABCD, 16'h1234, 1'b1, 1'b0);
    send("b2b_rd_b", 1'b0, 11'd100, 11'd101, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    send("b2b_wr", 1'b1, 11'd300, 11'd301, 16'h0001, 16'hFFFE, 16'h0, 16'h0, 1'b0, 1'b1);
    wait_idle("b2b");
    check("mem_300", mem[300], 16'h0001);
    check("mem_301", mem[301], 16'hFFFE);

    // Reset during the second WR_STROBE cycle.
    send("wr_abort", 1'b1, 11'd9, 11'd10, 16'h5555, 16'hAAAA, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_CS", bus.CS, 1'b1);
    check("abort_RW", bus.RW, 1'b0);
    check("abort_OE", bus.OE, 1'b0);
    check("abort_addr1", bus.MemAddress1, 11'd0);
    check("abort_rsp_valid", bus.rsp_valid, 1'b0);
    check("abort_ready", bus.req_ready, 1'b0);
    rst = 1'b0;
    exp_rd1 = 16'h0000;
    exp_rd2 = 16'h0000;
    repeat (12) @(negedge clk);
    send("rd_after_abort", 1'b0, 11'd5, 11'd2042, 16'h0, 16'h0, 16'h1234, 16'hABCD, 1'b0, 1'b0);
    wait_idle("rd_after_abort");

    // Never-written addresses read back as the SRAM init value.
    send("rd_unwritten", 1'b0, 11'd100, 11'd2047, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    wait_idle("rd_unwritten");

    // Write to the faulty address, then a clean write.
    send("wr_fault_7", 1'b1, 11'd7, 11'd8, 16'h0F0F, 16'h0F0F, 16'h0, 16'h0, 1'b0, 1'b0);
    wait_idle("wr_fault_7");
    send("wr_clean", 1'b1, 11'd20, 11'd21, 16'h0F0F, 16'hF0F0, 16'h0, 16'h0, 1'b0, 1'b0);
    wait_idle("wr_clean");
    check("mem_21", mem[21], 16'hF0F0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
